// File: rtl/rv_seq_ctrl.sv
// rtl/rv_seq_ctrl.sv - multi-cycle RV64 instruction sequencer; optional perf counters under SEQ_PERF_CNT_EN
module rv_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             retired,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH
  } cls_t;

  state_t              state_q, state_d;
  cls_t                cls_q, cls_d;
  logic                halt_q, halt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_hit;
  logic                halt_now;

  // The request that has waited MEM_TIMEOUT cycles without an ack gives up on this edge.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign halt_now    = halt_q | halt_req;
  assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault       = (state_q == S_FAULT);

  // State, instruction class, pending halt and memory wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_ALU;
      halt_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      halt_q  <= halt_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and strobes; the wait counter defaults to zero so it is clear on every FETCH/MEM entry.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    halt_d   = busy ? halt_now : halt_q;
    wait_d   = '0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    retired  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        halt_d = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          halt_d  = halt_req;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          7'b0110011, 7'b0010011: cls_d = C_ALU;
          7'b0000011:             cls_d = C_LOAD;
          7'b0100011:             cls_d = C_STORE;
          7'b1100011:             cls_d = C_BRANCH;
          default:                state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        unique case (cls_q)
          C_ALU:            state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken;
            retired = 1'b1;
            state_d = halt_now ? S_IDLE : S_FETCH;
            if (halt_now) halt_d = 1'b0;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ack) begin
          if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = halt_now ? S_IDLE : S_FETCH;
            if (halt_now) halt_d = 1'b0;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = (cls_q == C_LOAD);
        pc_we   = 1'b1;
        retired = 1'b1;
        state_d = halt_now ? S_IDLE : S_FETCH;
        if (halt_now) halt_d = 1'b0;
      end
      S_FAULT: ;
      default: state_d = S_FAULT;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, inst_q;

  // Busy-cycle and retired-instruction counters, wrapping, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      if (busy)    cyc_q  <= cyc_q + CNT_W'(1);
      if (retired) inst_q <= inst_q + CNT_W'(1);
    end
  end

  assign cyc_cnt  = cyc_q;
  assign inst_cnt = inst_q;
`else
  assign cyc_cnt  = '0;
  assign inst_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// tb/tb_rv_seq_ctrl.sv - randomized timeline-model bench for rv_seq_ctrl
module tb_rv_seq_ctrl;
  localparam int TMO = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, halt_req = 0, branch_taken = 0, imem_ack = 0, dmem_ack = 0;
  logic [6:0] opcode = '0;
  logic imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel, retired, busy, fault;
  logic [31:0] cyc_cnt, inst_cnt;
  logic [31:0] exp_cyc = 0, exp_inst = 0;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  rv_seq_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .opcode(opcode),
    .branch_taken(branch_taken), .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .retired(retired), .busy(busy),
    .fault(fault), .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
  );

  // {imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel, retired, busy, fault}
  wire [10:0] obs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel, retired, busy, fault};
  localparam logic [10:0] V_FAULT = 11'b00000000001;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  task automatic clear_inputs();
    start = 0; halt_req = 0; imem_ack = 0; dmem_ack = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    logic [31:0] ec, ei;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    exp_cyc = 0; exp_inst = 0;
    ec = 0; ei = 0;
    vectors++;
    if (obs !== 11'b0) begin miscompares++; $display("FAIL reset_outputs got=%b exp=%b", obs, 11'b0); end
    vectors++;
    if (cyc_cnt !== ec || inst_cnt !== ei) begin
      miscompares++; $display("FAIL reset_counters got=%0d/%0d exp=%0d/%0d", cyc_cnt, inst_cnt, ec, ei);
    end
    rst = 1'b0;
  endtask

  // Drives one instruction from FETCH entry and checks every cycle against a timeline
  // derived from the class latency rules: F fetch cycles, then decode, exec, memory, writeback.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic taken,
                           input bit from_idle, input bit start_halt, input bit halt_mid);
    bit isld, isst, isbr, ismem, ret;
    int f, l, hk;
    logic [10:0] e;
    logic [31:0] ec, ei;
    isld = (op == OP_LD); isst = (op == OP_ST); isbr = (op == OP_BR); ismem = isld | isst;
    f = fw + 1;
    l = isbr ? f + 2 : isst ? f + 3 + mw : isld ? f + 4 + mw : f + 3;
    hk = halt_mid ? $urandom_range(l - 1, 1) : 0;
    if (from_idle) begin start = 1'b1; halt_req = start_halt; end
    for (int k = 1; k <= l; k++) begin
      @(posedge clk); #1;
      start = 0;
      halt_req = (k == hk);
      opcode = (k > f) ? op : 7'($urandom);
      imem_ack = (k == f) || (k > f && $urandom_range(2, 0) == 0);
      if (ismem && k >= f + 3 && k <= f + 3 + mw) dmem_ack = (k == f + 3 + mw);
      else dmem_ack = ($urandom_range(2, 0) == 0);
      branch_taken = (k == f + 2) ? taken : 1'($urandom);
      @(negedge clk);
      ret = (k == l);
      e = {k <= f, k == f, ismem && k >= f + 3 && k <= f + 3 + mw,
           isst && k >= f + 3 && k <= f + 3 + mw, ret && !isbr && !isst, ret && isld,
           ret, ret && isbr && taken, ret, 1'b1, 1'b0};
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("FAIL instr op=%b k=%0d got=%b exp=%b", op, k, obs, e);
      end
    end
    exp_cyc += 32'(l); exp_inst += 1;
    if (start_halt || halt_mid) begin
      @(posedge clk); #1; clear_inputs();
      @(negedge clk);
      vectors++;
      if (obs !== 11'b0) begin miscompares++; $display("FAIL halt_idle got=%b exp=%b", obs, 11'b0); end
`ifdef SEQ_PERF_CNT_EN
      ec = exp_cyc; ei = exp_inst;
`else
      ec = 0; ei = 0;
`endif
      vectors++;
      if (cyc_cnt !== ec || inst_cnt !== ei) begin
        miscompares++; $display("FAIL counters got=%0d/%0d exp=%0d/%0d", cyc_cnt, inst_cnt, ec, ei);
      end
    end
  endtask

  task automatic test_r_type();
    run_instr(OP_R, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_load_wait();
    run_instr(OP_LD, 0, 2, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_branch();
    run_instr(OP_BR, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(OP_BR, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_halt_store();
    test_reset();
    run_instr(OP_ST, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_start_with_halt();
    run_instr(OP_I, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_wait_boundary();
    run_instr(OP_R, TMO - 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(OP_ST, 0, TMO - 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_LD, TMO - 1, TMO - 1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [5];
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST; ops[4] = OP_BR;
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(4, 0)], $urandom_range(TMO - 1, 0), $urandom_range(TMO - 1, 0),
                1'($urandom), n == 0, 1'b0, n == 39);
  endtask

  task automatic test_illegal();
    logic [31:0] ec;
    test_reset();
    start = 1'b1;
    @(posedge clk); #1; start = 0; imem_ack = 1; opcode = OP_BAD;
    @(negedge clk);
    vectors++;
    if (obs !== 11'b11000000010) begin miscompares++; $display("FAIL illegal_fetch got=%b", obs); end
    @(posedge clk); #1; imem_ack = 0;
    @(negedge clk);
    vectors++;
    if (obs !== 11'b00000000010) begin miscompares++; $display("FAIL illegal_decode got=%b", obs); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1; start = 1; imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (obs !== V_FAULT) begin miscompares++; $display("FAIL illegal_fault k=%0d got=%b exp=%b", k, obs, V_FAULT); end
    end
`ifdef SEQ_PERF_CNT_EN
    ec = 2;
`else
    ec = 0;
`endif
    vectors++;
    if (cyc_cnt !== ec || inst_cnt !== 0) begin
      miscompares++; $display("FAIL illegal_counters got=%0d/%0d exp=%0d/0", cyc_cnt, inst_cnt, ec);
    end
    test_reset();
  endtask

  task automatic test_timeout();
    logic [10:0] e;
    // Fetch never acked: request holds for TMO cycles, then FAULT ignores late acks.
    start = 1'b1;
    for (int k = 1; k <= TMO + 3; k++) begin
      @(posedge clk); #1; start = 0; imem_ack = (k > TMO);
      @(negedge clk);
      e = (k <= TMO) ? 11'b10000000010 : V_FAULT;
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL imem_timeout k=%0d got=%b exp=%b", k, obs, e); end
    end
    test_reset();
    // Store whose data access never completes.
    start = 1'b1;
    for (int k = 1; k <= TMO + 6; k++) begin
      @(posedge clk); #1; start = 0; imem_ack = (k == 1); opcode = OP_ST; dmem_ack = (k > TMO + 3);
      @(negedge clk);
      e = (k == 1) ? 11'b11000000010 : (k <= 3) ? 11'b00000000010 :
          (k <= TMO + 3) ? 11'b00110000010 : V_FAULT;
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL dmem_timeout k=%0d got=%b exp=%b", k, obs, e); end
    end
    test_reset();
  endtask

  task automatic test_async_rst();
    logic [10:0] e;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1; start = 0; imem_ack = (k == 1); opcode = OP_LD; dmem_ack = 0;
      @(negedge clk);
      e = (k == 1) ? 11'b11000000010 : (k <= 3) ? 11'b00000000010 : 11'b00100000010;
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL async_pre k=%0d got=%b exp=%b", k, obs, e); end
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 11'b0 || cyc_cnt !== 0 || inst_cnt !== 0) begin
      miscompares++; $display("FAIL async_rst got=%b cnt=%0d/%0d exp=%b cnt=0/0", obs, cyc_cnt, inst_cnt, 11'b0);
    end
    exp_cyc = 0; exp_inst = 0;
    clear_inputs();
    @(negedge clk); rst = 1'b0;
    run_instr(OP_R, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_halt_store();
    test_start_with_halt();
    test_wait_boundary();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
